// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 640x480@60 Hz region constants, counter widths
// and a small window-decode helper used by the raster counters.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;   // hCount / vCount width
  localparam int FC_W  = 8;    // frame counter width

  localparam int CLK_DIV_DEF  = 4;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // True when lo <= c < hi (half-open window, used for sync pulse decode).
  function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return (c >= CNT_W'(lo)) && (c < CNT_W'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the
// pixel-drawing logic and the VGA connector.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             bright;
  logic             hSync;
  logic             vSync;
  logic             pix_en;
  logic             line_start;
  logic             frame_start;
  logic [FC_W-1:0]  frame_count;

  modport master (
    output hCount, vCount, bright, hSync, vSync,
    output pix_en, line_start, frame_start, frame_count
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync,
    input pix_en, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 on inc, and registers the active/sync decode of the next count
// so the decoded levels always line up with the presented count.
// wrap is a one-cycle flag, high in the cycle after the count wrapped to 0.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync_n
);

  localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC;

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             active_q, active_d;
  logic             sync_n_q, sync_n_d;
  logic             at_last_s;

  // Next-count and its decode; levels are computed from count_d, not count_q.
  always_comb begin
    at_last_s = (count_q == CNT_W'(TOTAL - 1));
    count_d   = count_q;
    wrap_d    = 1'b0;
    if (inc) begin
      if (at_last_s) begin
        count_d = {CNT_W{1'b0}};
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        wrap_d  = 1'b0;
      end
    end else begin
      count_d = count_q;
      wrap_d  = 1'b0;
    end
    active_d = (count_d < CNT_W'(ACTIVE));
    sync_n_d = ~in_window(count_d, SYNC_LO, SYNC_HI);
  end

  // Axis state; reset presents count 0, which decodes as active and sync idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= {CNT_W{1'b0}};
      wrap_q   <= 1'b0;
      active_q <= 1'b1;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign active = active_q;
  assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480@60 Hz VGA raster timing from the
// system clock. Contains the pixel clock divider, the pixel strobe and the
// optional frame counter; the two raster axes live in vga_axis_counter.
// Optional feature macro: VGA_FRAME_COUNTER_EN (frame_count counts frames;
// when undefined frame_count is tied to zero and no counter is built).
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q;
  logic             adv_s;
  logic             v_inc_s;
  logic [CNT_W-1:0] h_count_s, v_count_s;
  logic             h_wrap_s, v_wrap_s;
  logic             h_active_s, v_active_s;
  logic             h_sync_n_s, v_sync_n_s;

  // Pixel divider: advance tick on the last divider phase; CLK_DIV=1 ticks every cycle.
  always_comb begin
    adv_s = (div_cnt_q == DIV_LAST);
    if (adv_s) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    v_inc_s = adv_s && (h_count_s == CNT_W'(H_TOTAL - 1));
  end

  // Divider state and the pixel strobe, high the cycle after each advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= {DIV_W{1'b0}};
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= adv_s;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (adv_s),
    .count  (h_count_s),
    .wrap   (h_wrap_s),
    .active (h_active_s),
    .sync_n (h_sync_n_s)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (v_inc_s),
    .count  (v_count_s),
    .wrap   (v_wrap_s),
    .active (v_active_s),
    .sync_n (v_sync_n_s)
  );

`ifdef VGA_FRAME_COUNTER_EN
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            fc_inc_s;

  // Frame counter steps on the same edge that raises frame_start, wrapping mod 256.
  always_comb begin
    fc_inc_s = v_inc_s && (v_count_s == CNT_W'(V_TOTAL - 1));
    if (fc_inc_s) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= {FC_W{1'b0}};
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.frame_count = frame_cnt_q;
`else
  assign vga.frame_count = 8'h00;
`endif

  // A vertical wrap only happens on a horizontal wrap, so v_wrap alone marks (0,0).
  assign vga.hCount      = h_count_s;
  assign vga.vCount      = v_count_s;
  assign vga.bright      = h_active_s & v_active_s;
  assign vga.hSync       = h_sync_n_s;
  assign vga.vSync       = v_sync_n_s;
  assign vga.pix_en      = pix_en_q;
  assign vga.line_start  = h_wrap_s;
  assign vga.frame_start = v_wrap_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed, table-driven bench. DUT A uses the real
// 640x480 timing for reset/line checks; DUT B uses a tiny raster
// (CLK_DIV=2, H 4/1/2/1, V 3/1/2/1) so vertical, frame and reset corner
// cases fit in a short run.
module tb_vga_timing_gen;

  typedef struct {
    int k;   // clk edges since reset release
    int h;
    int v;
    int b;
    int hs;
    int vs;
    int pe;
    int ls;
    int fs;
  } vec_t;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen u_dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .vga   (if_a)
  );

  vga_timing_gen #(
    .CLK_DIV  (2),
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .vga   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input bit sel, input vec_t e, input string tag);
    int h, v, b, hs, vs, pe, ls, fs;
    if (!sel) begin
      h = int'(if_a.hCount); v = int'(if_a.vCount); b = int'(if_a.bright);
      hs = int'(if_a.hSync); vs = int'(if_a.vSync); pe = int'(if_a.pix_en);
      ls = int'(if_a.line_start); fs = int'(if_a.frame_start);
    end else begin
      h = int'(if_b.hCount); v = int'(if_b.vCount); b = int'(if_b.bright);
      hs = int'(if_b.hSync); vs = int'(if_b.vSync); pe = int'(if_b.pix_en);
      ls = int'(if_b.line_start); fs = int'(if_b.frame_start);
    end
    chk($sformatf("%s k=%0d hCount", tag, e.k), h, e.h);
    chk($sformatf("%s k=%0d vCount", tag, e.k), v, e.v);
    chk($sformatf("%s k=%0d bright", tag, e.k), b, e.b);
    chk($sformatf("%s k=%0d hSync", tag, e.k), hs, e.hs);
    chk($sformatf("%s k=%0d vSync", tag, e.k), vs, e.vs);
    chk($sformatf("%s k=%0d pix_en", tag, e.k), pe, e.pe);
    chk($sformatf("%s k=%0d line_start", tag, e.k), ls, e.ls);
    chk($sformatf("%s k=%0d frame_start", tag, e.k), fs, e.fs);
  endtask

  // Walk a table of (edge count, expected outputs); caller releases reset at a negedge.
  task automatic walk(input bit sel, input vec_t tab[$], input string tag);
    int k = 0;
    foreach (tab[i]) begin
      while (k < tab[i].k) begin
        @(negedge clk);
        k++;
      end
      check_vec(sel, tab[i], tag);
    end
  endtask

  // Wait for the next frame_start on DUT B; returns cycles waited, or -1 on timeout.
  task automatic wait_fs_b(input int bound, output int cyc);
    cyc = -1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (if_b.frame_start === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t rst_vec;
    int   cyc;
    bit   found;

    //           k     h    v  b hs vs pe ls fs
    tab_a.push_back('{0,    0,   0, 1, 1, 1, 0, 0, 0});
    tab_a.push_back('{3,    0,   0, 1, 1, 1, 0, 0, 0});
    tab_a.push_back('{4,    1,   0, 1, 1, 1, 1, 0, 0});
    tab_a.push_back('{5,    1,   0, 1, 1, 1, 0, 0, 0});
    tab_a.push_back('{2559, 639, 0, 1, 1, 1, 0, 0, 0});
    tab_a.push_back('{2560, 640, 0, 0, 1, 1, 1, 0, 0});
    tab_a.push_back('{2623, 655, 0, 0, 1, 1, 0, 0, 0});
    tab_a.push_back('{2624, 656, 0, 0, 0, 1, 1, 0, 0});
    tab_a.push_back('{3007, 751, 0, 0, 0, 1, 0, 0, 0});
    tab_a.push_back('{3008, 752, 0, 0, 1, 1, 1, 0, 0});
    tab_a.push_back('{3199, 799, 0, 0, 1, 1, 0, 0, 0});
    tab_a.push_back('{3200, 0,   1, 1, 1, 1, 1, 1, 0});
    tab_a.push_back('{3201, 0,   1, 1, 1, 1, 0, 0, 0});
    tab_a.push_back('{3204, 1,   1, 1, 1, 1, 1, 0, 0});

    //           k    h  v  b hs vs pe ls fs
    tab_b.push_back('{0,   0, 0, 1, 1, 1, 0, 0, 0});
    tab_b.push_back('{1,   0, 0, 1, 1, 1, 0, 0, 0});
    tab_b.push_back('{2,   1, 0, 1, 1, 1, 1, 0, 0});
    tab_b.push_back('{8,   4, 0, 0, 1, 1, 1, 0, 0});
    tab_b.push_back('{10,  5, 0, 0, 0, 1, 1, 0, 0});
    tab_b.push_back('{13,  6, 0, 0, 0, 1, 0, 0, 0});
    tab_b.push_back('{14,  7, 0, 0, 1, 1, 1, 0, 0});
    tab_b.push_back('{16,  0, 1, 1, 1, 1, 1, 1, 0});
    tab_b.push_back('{47,  7, 2, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{48,  0, 3, 0, 1, 1, 1, 1, 0});
    tab_b.push_back('{63,  7, 3, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{64,  0, 4, 0, 1, 0, 1, 1, 0});
    tab_b.push_back('{80,  0, 5, 0, 1, 0, 1, 1, 0});
    tab_b.push_back('{96,  0, 6, 0, 1, 1, 1, 1, 0});
    tab_b.push_back('{111, 7, 6, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{112, 0, 0, 1, 1, 1, 1, 1, 1});
    tab_b.push_back('{113, 0, 0, 1, 1, 1, 0, 0, 0});

    rst_vec = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check_vec(1'b0, rst_vec, "A in reset");
    chk("A in reset frame_count", int'(if_a.frame_count), 0);

    // Full-size raster: first pixel latency and one complete line.
    rst_a_n = 1'b1;
    walk(1'b0, tab_a, "A");
    chk("A line0 frame_count", int'(if_a.frame_count), 0);

    // Tiny raster: vertical sync, blanking and frame wrap.
    @(negedge clk);
    rst_b_n = 1'b1;
    walk(1'b1, tab_b, "B");

    // Frame period between consecutive frame_start pulses.
    wait_fs_b(300, cyc);
    chk("B frame_start found", int'(cyc > 0), 1);
    chk("B fs1 hCount", int'(if_b.hCount), 0);
    chk("B fs1 vCount", int'(if_b.vCount), 0);
    wait_fs_b(300, cyc);
    chk("B frame period clk", cyc, 112);
    chk("B fs2 hCount", int'(if_b.hCount), 0);
    chk("B fs2 vCount", int'(if_b.vCount), 0);

    // Frame counter over 257 frames from a fresh reset.
    @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    chk("B reset frame_count", int'(if_b.frame_count), 0);
    rst_b_n = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      wait_fs_b(200, cyc);
      if (cyc < 0) begin
        chk($sformatf("B frame %0d frame_start timeout", i), cyc, 112);
        break;
      end
`ifdef VGA_FRAME_COUNTER_EN
      chk($sformatf("B frame %0d frame_count", i), int'(if_b.frame_count), i % 256);
`else
      chk($sformatf("B frame %0d frame_count", i), int'(if_b.frame_count), 0);
`endif
    end

    // Mid-frame, mid-cycle asynchronous reset at (3,2).
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (if_b.hCount == 10'd3 && if_b.vCount == 10'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("B reach (3,2)", int'(found), 1);
    #2;
    rst_b_n = 1'b0;
    #1;
    check_vec(1'b1, rst_vec, "B async reset");
    chk("B async reset frame_count", int'(if_b.frame_count), 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    tab_b.delete();
    tab_b.push_back('{0, 0, 0, 1, 1, 1, 0, 0, 0});
    tab_b.push_back('{1, 0, 0, 1, 1, 1, 0, 0, 0});
    tab_b.push_back('{2, 1, 0, 1, 1, 1, 1, 0, 0});
    tab_b.push_back('{3, 1, 0, 1, 1, 1, 0, 0, 0});
    walk(1'b1, tab_b, "B restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
